// File: rtl/pipelined_control_unit.sv
// RV32I control unit: decodes the ID instruction and carries its control bundle through the ID/EX, EX/MEM and MEM/WB registers.
// Also detects load-use hazards, inserts bubbles, and keeps a saturating count of illegal instructions.
module pipelined_control_unit #(
    parameter bit EN_UTYPE  = 1'b1,
    parameter bit EN_HAZARD = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic                 stall_in,
    input  logic                 flush_in,
    output logic                 hazard_stall,
    output logic                 ex_valid,
    output logic [1:0]           ex_alu_a,
    output logic                 ex_alu_b,
    output logic [3:0]           ex_alu_op,
    output logic [2:0]           ex_imm_src,
    output logic [4:0]           ex_branch_op,
    output logic                 ex_illegal,
    output logic                 mem_valid,
    output logic                 mem_data_write_en,
    output logic [2:0]           mem_dm_control,
    output logic                 wb_valid,
    output logic                 wb_reg_write_en,
    output logic [1:0]           wb_rd_data_sel,
    output logic [4:0]           wb_rd,
    output logic                 ill_seen,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [1:0] alu_a;
        logic       alu_b;
        logic [3:0] alu_op;
        logic [2:0] imm_src;
        logic [4:0] branch_op;
        logic       data_write_en;
        logic [2:0] dm_control;
        logic       reg_write_en;
        logic [1:0] rd_data_sel;
        logic [4:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       data_write_en;
        logic [2:0] dm_control;
        logic       reg_write_en;
        logic [1:0] rd_data_sel;
        logic [4:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write_en;
        logic [1:0] rd_data_sel;
        logic [4:0] rd;
    } wb_ctrl_t;

    function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] cnt);
        return (cnt == {ILL_CNT_W{1'b1}}) ? cnt : cnt + ILL_CNT_W'(1);
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_legal;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_hazard;
    ex_ctrl_t   w_dec;
    ex_ctrl_t   w_id;

    ex_ctrl_t         r_ex;
    mem_ctrl_t        r_mem;
    wb_ctrl_t         r_wb;
    logic             r_ill_seen;
    logic [ILL_CNT_W-1:0] r_ill_count;

    assign w_opcode = id_instr[6:0];
    assign w_rd     = id_instr[11:7];
    assign w_funct3 = id_instr[14:12];
    assign w_rs1    = id_instr[19:15];
    assign w_rs2    = id_instr[24:20];
    assign w_funct7 = id_instr[31:25];

    // ID stage: raw decode of the opcode group; legality decided alongside
    always_comb begin
        w_dec      = '0;
        w_legal    = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_rs1_used         = 1'b1;
                w_rs2_used         = 1'b1;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd           = w_rd;
                w_dec.alu_op       = {w_funct7[5], w_funct3};
                w_legal            = (w_funct7 == 7'h00) ||
                                     ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)));
            end
            OP_IMM: begin
                w_rs1_used         = 1'b1;
                w_dec.alu_b        = 1'b1;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd           = w_rd;
                w_dec.alu_op       = {1'b0, w_funct3};
                case (w_funct3)
                    3'd1:    w_legal = (w_funct7 == 7'h00);
                    3'd5: begin
                        w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                        if (w_funct7 == 7'h20) w_dec.alu_op = 4'b1101;
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_rs1_used         = 1'b1;
                w_dec.alu_b        = 1'b1;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd_data_sel  = 2'b01;
                w_dec.dm_control   = w_funct3;
                w_dec.rd           = w_rd;
                w_legal            = w_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            OP_STORE: begin
                w_rs1_used          = 1'b1;
                w_rs2_used          = 1'b1;
                w_dec.alu_b         = 1'b1;
                w_dec.imm_src       = 3'b001;
                w_dec.data_write_en = 1'b1;
                w_dec.dm_control    = w_funct3;
                w_legal             = w_funct3 inside {3'd0, 3'd1, 3'd2};
            end
            OP_BRANCH: begin
                w_rs1_used      = 1'b1;
                w_rs2_used      = 1'b1;
                w_dec.imm_src   = 3'b101;
                w_dec.branch_op = {2'b01, w_funct3};
                w_legal         = !(w_funct3 inside {3'd2, 3'd3});
            end
            OP_LUI, OP_AUIPC: begin
                w_dec.alu_a        = (w_opcode == OP_LUI) ? 2'b10 : 2'b01;
                w_dec.alu_b        = 1'b1;
                w_dec.imm_src      = 3'b010;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd           = w_rd;
                w_legal            = EN_UTYPE;
            end
            OP_JAL: begin
                w_dec.alu_a        = 2'b01;
                w_dec.alu_b        = 1'b1;
                w_dec.imm_src      = 3'b110;
                w_dec.rd_data_sel  = 2'b10;
                w_dec.branch_op    = 5'b10000;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd           = w_rd;
                w_legal            = 1'b1;
            end
            OP_JALR: begin
                w_rs1_used         = 1'b1;
                w_dec.alu_b        = 1'b1;
                w_dec.rd_data_sel  = 2'b10;
                w_dec.branch_op    = 5'b10000;
                w_dec.reg_write_en = 1'b1;
                w_dec.rd           = w_rd;
                w_legal            = (w_funct3 == 3'd0);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal or absent instructions become bubbles; only a real illegal word raises the flag
    always_comb begin
        w_id = '0;
        if (id_valid) begin
            if (w_legal) begin
                w_id       = w_dec;
                w_id.valid = 1'b1;
            end else begin
                w_id.illegal = 1'b1;
            end
        end
    end

    // A load in EX is recognised by its memory write-back select
    assign w_hazard = EN_HAZARD && r_ex.valid && (r_ex.rd_data_sel == 2'b01) && (r_ex.rd != 5'd0) &&
                      id_valid && ((w_rs1_used && (w_rs1 == r_ex.rd)) || (w_rs2_used && (w_rs2 == r_ex.rd)));
    assign hazard_stall = w_hazard;

    // ID/EX, EX/MEM, MEM/WB boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_ill_seen  <= 1'b0;
            r_ill_count <= '0;
        end else if (!stall_in) begin
            r_mem.valid         <= r_ex.valid;
            r_mem.data_write_en <= r_ex.data_write_en;
            r_mem.dm_control    <= r_ex.dm_control;
            r_mem.reg_write_en  <= r_ex.reg_write_en;
            r_mem.rd_data_sel   <= r_ex.rd_data_sel;
            r_mem.rd            <= r_ex.rd;
            r_wb.valid          <= r_mem.valid;
            r_wb.reg_write_en   <= r_mem.reg_write_en;
            r_wb.rd_data_sel    <= r_mem.rd_data_sel;
            r_wb.rd             <= r_mem.rd;
            if (flush_in || w_hazard) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id;
                if (w_id.illegal) begin
                    r_ill_seen  <= 1'b1;
                    r_ill_count <= sat_inc(r_ill_count);
                end
            end
        end
    end

    assign ex_valid          = r_ex.valid;
    assign ex_alu_a          = r_ex.alu_a;
    assign ex_alu_b          = r_ex.alu_b;
    assign ex_alu_op         = r_ex.alu_op;
    assign ex_imm_src        = r_ex.imm_src;
    assign ex_branch_op      = r_ex.branch_op;
    assign ex_illegal        = r_ex.illegal;
    assign mem_valid         = r_mem.valid;
    assign mem_data_write_en = r_mem.data_write_en;
    assign mem_dm_control    = r_mem.dm_control;
    assign wb_valid          = r_wb.valid;
    assign wb_reg_write_en   = r_wb.reg_write_en;
    assign wb_rd_data_sel    = r_wb.rd_data_sel;
    assign wb_rd             = r_wb.rd;
    assign ill_seen          = r_ill_seen;
    assign ill_count         = r_ill_count;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus a randomized run against a mnemonic-level pipeline model.
// A second instance with EN_HAZARD = 0 and EN_UTYPE = 0 shares the same stimulus.
module tb_pipelined_control_unit;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD65 = 32'h00028333;
    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_SRAI  = 32'h4030D113;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] I_SW    = 32'h0020A223;

    logic clk = 1'b0;
    logic rst_n, id_valid, stall_in, flush_in;
    logic [31:0] id_instr;

    logic hazard_stall, ex_valid, ex_alu_b, ex_illegal, mem_valid, mem_data_write_en;
    logic wb_valid, wb_reg_write_en, ill_seen;
    logic [1:0] ex_alu_a, wb_rd_data_sel;
    logic [3:0] ex_alu_op;
    logic [2:0] ex_imm_src, mem_dm_control;
    logic [4:0] ex_branch_op, wb_rd;
    logic [7:0] ill_count;

    logic n_hazard_stall, n_ex_valid, n_ex_alu_b, n_ex_illegal, n_mem_valid, n_mem_data_write_en;
    logic n_wb_valid, n_wb_reg_write_en, n_ill_seen;
    logic [1:0] n_ex_alu_a, n_wb_rd_data_sel;
    logic [3:0] n_ex_alu_op;
    logic [2:0] n_ex_imm_src, n_mem_dm_control;
    logic [4:0] n_ex_branch_op, n_wb_rd;
    logic [7:0] n_ill_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
        .ex_imm_src(ex_imm_src), .ex_branch_op(ex_branch_op), .ex_illegal(ex_illegal),
        .mem_valid(mem_valid), .mem_data_write_en(mem_data_write_en), .mem_dm_control(mem_dm_control),
        .wb_valid(wb_valid), .wb_reg_write_en(wb_reg_write_en), .wb_rd_data_sel(wb_rd_data_sel),
        .wb_rd(wb_rd), .ill_seen(ill_seen), .ill_count(ill_count)
    );

    pipelined_control_unit #(.EN_UTYPE(1'b0), .EN_HAZARD(1'b0), .ILL_CNT_W(8)) dut_nh (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(n_hazard_stall),
        .ex_valid(n_ex_valid), .ex_alu_a(n_ex_alu_a), .ex_alu_b(n_ex_alu_b), .ex_alu_op(n_ex_alu_op),
        .ex_imm_src(n_ex_imm_src), .ex_branch_op(n_ex_branch_op), .ex_illegal(n_ex_illegal),
        .mem_valid(n_mem_valid), .mem_data_write_en(n_mem_data_write_en), .mem_dm_control(n_mem_dm_control),
        .wb_valid(n_wb_valid), .wb_reg_write_en(n_wb_reg_write_en), .wb_rd_data_sel(n_wb_rd_data_sel),
        .wb_rd(n_wb_rd), .ill_seen(n_ill_seen), .ill_count(n_ill_count)
    );

    // ---------------- reference model (main instance) ----------------
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       ld;
        logic [1:0] alu_a;
        logic       alu_b;
        logic [3:0] alu_op;
        logic [2:0] imm_src;
        logic [4:0] br;
        logic       dwe;
        logic [2:0] dm;
        logic       rwe;
        logic [1:0] rsel;
        logic [4:0] rd;
    } mdl_t;

    mdl_t m_ex, m_mem, m_wb;
    bit   m_seen;
    int   m_cnt;

    function automatic mdl_t ref_decode(input logic v, input logic [31:0] ins, input bit en_u);
        mdl_t b;
        bit ok;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd;
        op = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12]; rd = ins[11:7];
        b = '0; ok = 0;
        case (op)
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                b.alu_op = (f7 == 7'h20) ? {1'b1, f3} : {1'b0, f3};
                b.rwe = 1; b.rd = rd;
            end
            7'h13: begin
                b.alu_b = 1; b.rwe = 1; b.rd = rd; b.alu_op = {1'b0, f3};
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 7'h20);
                    if (f7 == 7'h20) b.alu_op = 4'b1101;
                end else ok = 1;
            end
            7'h03: begin
                ok = (f3 != 3) && (f3 < 6);
                b.ld = 1; b.alu_b = 1; b.rwe = 1; b.rsel = 2'b01; b.dm = f3; b.rd = rd;
            end
            7'h23: begin
                ok = (f3 < 3);
                b.alu_b = 1; b.imm_src = 3'b001; b.dwe = 1; b.dm = f3;
            end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3);
                b.imm_src = 3'b101; b.br = {2'b01, f3};
            end
            7'h37, 7'h17: begin
                ok = en_u;
                b.alu_a = (op == 7'h37) ? 2'b10 : 2'b01;
                b.alu_b = 1; b.imm_src = 3'b010; b.rwe = 1; b.rd = rd;
            end
            7'h6F: begin
                ok = 1; b.alu_a = 2'b01; b.alu_b = 1; b.imm_src = 3'b110;
                b.rsel = 2'b10; b.br = 5'b10000; b.rwe = 1; b.rd = rd;
            end
            7'h67: begin
                ok = (f3 == 0); b.alu_b = 1; b.rsel = 2'b10; b.br = 5'b10000; b.rwe = 1; b.rd = rd;
            end
            default: ok = 0;
        endcase
        if (!v) b = '0;
        else if (!ok) begin b = '0; b.illegal = 1; end
        else b.valid = 1;
        return b;
    endfunction

    function automatic logic [1:0] ref_uses(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h23, 7'h63: return 2'b11;
            7'h13, 7'h03, 7'h67: return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

    function automatic bit ref_hazard();
        logic [1:0] u;
        u = ref_uses(id_instr);
        return m_ex.valid && m_ex.ld && (m_ex.rd != 0) && id_valid &&
               ((u[1] && id_instr[19:15] == m_ex.rd) || (u[0] && id_instr[24:20] == m_ex.rd));
    endfunction

    always @(posedge clk) begin
        mdl_t nb;
        bit hz;
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_seen = 0; m_cnt = 0;
        end else if (!stall_in) begin
            hz = ref_hazard();
            nb = ref_decode(id_valid, id_instr, 1'b1);
            m_wb  = m_mem;
            m_mem = m_ex;
            if (flush_in || hz) m_ex = '0;
            else begin
                m_ex = nb;
                if (nb.illegal) begin
                    m_seen = 1;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    function automatic logic [39:0] exp_vec();
        logic [7:0] c;
        c = m_cnt[7:0];
        return {m_ex.valid, m_ex.illegal, m_ex.alu_a, m_ex.alu_b, m_ex.alu_op, m_ex.imm_src, m_ex.br,
                m_mem.valid, m_mem.dwe, m_mem.dm,
                m_wb.valid, m_wb.rwe, m_wb.rsel, m_wb.rd, m_seen, c};
    endfunction

    function automatic logic [39:0] act_vec();
        return {ex_valid, ex_illegal, ex_alu_a, ex_alu_b, ex_alu_op, ex_imm_src, ex_branch_op,
                mem_valid, mem_data_write_en, mem_dm_control,
                wb_valid, wb_reg_write_en, wb_rd_data_sel, wb_rd, ill_seen, ill_count};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        rst_n = 0; id_valid = 0; stall_in = 0; flush_in = 0; id_instr = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        logic [6:0] f7;
        int k;
        rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        k  = $urandom_range(0, 2);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
        case ($urandom_range(0, 11))
            0:       return {f7, r2, r1, f3, rd, 7'h33};
            1:       return {f7, r2, r1, f3, rd, 7'h13};
            2, 3, 4: return {7'($urandom), 5'($urandom), r1, f3, rd, 7'h03};
            5:       return {f7, r2, r1, f3, 5'($urandom), 7'h23};
            6:       return {f7, r2, r1, f3, 5'($urandom), 7'h63};
            7:       return {20'($urandom), rd, 7'h37};
            8:       return {20'($urandom), rd, 7'h17};
            9:       return {20'($urandom), rd, 7'h6F};
            10:      return {12'($urandom), r1, (k == 2) ? f3 : 3'd0, rd, 7'h67};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; id_valid = 1; id_instr = I_ADD; stall_in = 0; flush_in = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({act_vec(), hazard_stall} !== 41'h0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {act_vec(), hazard_stall});
        end
        total++;
        if ({n_ex_valid, n_ex_illegal, n_mem_valid, n_wb_valid, n_ill_seen, n_ill_count} !== 13'h0) begin
            bad++; $display("FAIL reset_outputs_nh got=%h want=0",
                            {n_ex_valid, n_ex_illegal, n_mem_valid, n_wb_valid, n_ill_seen, n_ill_count});
        end
        rst_n = 1;
        @(negedge clk);
        total++;
        if ({ex_valid, ex_alu_op, ex_alu_b, ex_alu_a} !== {1'b1, 4'b0000, 1'b0, 2'b00}) begin
            bad++; $display("FAIL add_ex got=%b want=%b", {ex_valid, ex_alu_op, ex_alu_b, ex_alu_a}, 8'b1_0000_0_00);
        end
        id_valid = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({wb_valid, wb_reg_write_en, wb_rd_data_sel, wb_rd} !== {1'b1, 1'b1, 2'b00, 5'd3}) begin
            bad++; $display("FAIL add_wb got=%b want=%b", {wb_valid, wb_reg_write_en, wb_rd_data_sel, wb_rd}, 9'b1_1_00_00011);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        id_valid = 1; id_instr = I_LW;
        @(negedge clk);
        id_instr = I_ADD65;
        #1;
        total++;
        if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", hazard_stall); end
        total++;
        if (n_hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_stall_nh got=%b want=0", n_hazard_stall); end
        @(negedge clk);
        total++;
        if ({hazard_stall, ex_valid, mem_valid} !== 3'b001) begin
            bad++; $display("FAIL lu_bubble got=%b want=001", {hazard_stall, ex_valid, mem_valid});
        end
        total++;
        if ({n_ex_valid, n_ex_alu_op, n_ex_alu_b} !== 6'b1_0000_0) begin
            bad++; $display("FAIL lu_nh_add got=%b want=100000", {n_ex_valid, n_ex_alu_op, n_ex_alu_b});
        end
        @(negedge clk);
        total++;
        if ({ex_valid, ex_alu_op, ex_alu_b, hazard_stall} !== 7'b1_0000_0_0) begin
            bad++; $display("FAIL lu_add_ex got=%b want=1000000", {ex_valid, ex_alu_op, ex_alu_b, hazard_stall});
        end
        id_valid = 0;
    endtask

    task automatic test_utype_srai();
        apply_reset();
        id_valid = 1; id_instr = I_LUI;
        @(negedge clk);
        total++;
        if ({ex_valid, ex_alu_a, ex_alu_b, ex_imm_src, ex_alu_op} !== {1'b1, 2'b10, 1'b1, 3'b010, 4'b0000}) begin
            bad++; $display("FAIL lui_ex got=%b want=%b", {ex_valid, ex_alu_a, ex_alu_b, ex_imm_src, ex_alu_op}, 11'b1_10_1_010_0000);
        end
        total++;
        if ({n_ex_valid, n_ex_illegal} !== 2'b01) begin
            bad++; $display("FAIL lui_nh_illegal got=%b want=01", {n_ex_valid, n_ex_illegal});
        end
        id_instr = I_SRAI;
        @(negedge clk);
        total++;
        if ({ex_valid, ex_alu_op, ex_alu_b, ex_alu_a} !== {1'b1, 4'b1101, 1'b1, 2'b00}) begin
            bad++; $display("FAIL srai_ex got=%b want=%b", {ex_valid, ex_alu_op, ex_alu_b, ex_alu_a}, 8'b1_1101_1_00);
        end
        id_valid = 0;
        @(negedge clk);
        total++;
        if ({wb_valid, wb_reg_write_en, wb_rd} !== {1'b1, 1'b1, 5'd1}) begin
            bad++; $display("FAIL lui_wb got=%b want=%b", {wb_valid, wb_reg_write_en, wb_rd}, 7'b1_1_00001);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        id_valid = 1; id_instr = I_ILL;
        @(negedge clk);
        total++;
        if ({ex_illegal, ex_valid, ex_branch_op, ill_seen, ill_count} !== {1'b1, 1'b0, 5'd0, 1'b1, 8'd1}) begin
            bad++; $display("FAIL ill_first got=%h want=%h", {ex_illegal, ex_valid, ex_branch_op, ill_seen, ill_count},
                            {1'b1, 1'b0, 5'd0, 1'b1, 8'd1});
        end
        repeat (299) @(negedge clk);
        total++;
        if (ill_count !== 8'd255) begin bad++; $display("FAIL ill_saturate got=%0d want=255", ill_count); end
        total++;
        if ({mem_valid, mem_data_write_en, wb_valid, wb_reg_write_en} !== 4'b0000) begin
            bad++; $display("FAIL ill_no_enables got=%b want=0000", {mem_valid, mem_data_write_en, wb_valid, wb_reg_write_en});
        end
        id_valid = 0;
    endtask

    task automatic test_flush_stall();
        apply_reset();
        id_valid = 1; id_instr = I_ILL; flush_in = 1;
        @(negedge clk);
        total++;
        if ({ex_illegal, ex_valid, ill_seen, ill_count} !== 11'h0) begin
            bad++; $display("FAIL flush_ill got=%h want=0", {ex_illegal, ex_valid, ill_seen, ill_count});
        end
        id_instr = I_ADD;
        @(negedge clk);
        total++;
        if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", ex_valid); end
        flush_in = 0;
        @(negedge clk);
        id_instr = I_SW;
        @(negedge clk);
        stall_in = 1; flush_in = 1; id_instr = I_LUI;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({ex_valid, ex_imm_src, mem_valid, mem_data_write_en, wb_valid} !== 7'b1_001_1_0_0) begin
                bad++; $display("FAIL stall_hold%0d got=%b want=1001100", i,
                                {ex_valid, ex_imm_src, mem_valid, mem_data_write_en, wb_valid});
            end
        end
        stall_in = 0;
        @(negedge clk);
        total++;
        if ({ex_valid, mem_data_write_en, wb_valid, wb_rd} !== {1'b0, 1'b1, 1'b1, 5'd3}) begin
            bad++; $display("FAIL stall_release got=%b want=%b", {ex_valid, mem_data_write_en, wb_valid, wb_rd}, 8'b0_1_1_00011);
        end
        flush_in = 0; id_valid = 0;
    endtask

    task automatic test_store();
        apply_reset();
        id_valid = 1; id_instr = I_SW;
        @(negedge clk);
        total++;
        if ({ex_valid, ex_alu_b, ex_imm_src, ex_alu_op} !== {1'b1, 1'b1, 3'b001, 4'b0000}) begin
            bad++; $display("FAIL sw_ex got=%b want=%b", {ex_valid, ex_alu_b, ex_imm_src, ex_alu_op}, 9'b1_1_001_0000);
        end
        id_valid = 0;
        @(negedge clk);
        total++;
        if ({mem_valid, mem_data_write_en, mem_dm_control} !== 5'b1_1_010) begin
            bad++; $display("FAIL sw_mem got=%b want=11010", {mem_valid, mem_data_write_en, mem_dm_control});
        end
        @(negedge clk);
        total++;
        if ({wb_valid, wb_reg_write_en, wb_rd} !== {1'b1, 1'b0, 5'd0}) begin
            bad++; $display("FAIL sw_wb got=%b want=1000000", {wb_valid, wb_reg_write_en, wb_rd});
        end
    endtask

    task automatic test_random();
        bit hz_exp;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            stall_in = ($urandom_range(0, 99) < 15);
            flush_in = ($urandom_range(0, 99) < 10);
            id_valid = ($urandom_range(0, 99) < 85);
            id_instr = gen_instr();
            #1;
            hz_exp = ref_hazard();
            total++;
            if (hazard_stall !== hz_exp) begin
                bad++; $display("FAIL rand_hazard cyc=%0d instr=%h got=%b want=%b", c, id_instr, hazard_stall, hz_exp);
            end
            total++;
            if (n_hazard_stall !== 1'b0) begin
                bad++; $display("FAIL rand_hazard_nh cyc=%0d got=%b want=0", c, n_hazard_stall);
            end
            @(negedge clk);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_state cyc=%0d got=%h want=%h", c, act_vec(), exp_vec());
            end
        end
        rst_n = 1; stall_in = 0; flush_in = 0; id_valid = 0;
    endtask

    initial begin
        rst_n = 0; id_valid = 0; stall_in = 0; flush_in = 0; id_instr = 32'h0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_utype_srai();
        test_illegal();
        test_flush_stall();
        test_store();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
